// File: rtl/switch_cfg_pkg.sv
// ---------------------------------------------------------------------------
// switch_cfg_pkg
// Shared definitions for the switch configuration loader: frame header
// constant, loader FSM state encoding and the payload byte-count helper.
// ---------------------------------------------------------------------------
package switch_cfg_pkg;

   localparam logic [7:0] CFG_HEADER = 8'hA5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CSUM    = 2'd2,
      APPLY   = 2'd3
   } cfg_state_t;

   // Number of payload bytes needed to cover num_sw enables.
   function automatic int cfg_nbytes(input int num_sw);
      return (num_sw + 7) / 8;
   endfunction

endpackage

// File: rtl/switch_config_loader.sv
// ---------------------------------------------------------------------------
// switch_config_loader
// Accepts framed configuration bytes (0xA5, NBYTES payload bytes, XOR
// checksum) and commits the assembled shadow register to the switch enables
// in a single cycle, so the fabric never sees a half-loaded routing state.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   cfg_data   configuration byte
//   cfg_valid  cfg_data valid
//   cfg_ready  loader can accept a byte (state decode only)
//   sw_clear   synchronous kill: enables off, frame aborted
//   enable     registered switch enables, bit i drives switch i
//   cfg_done   one-cycle pulse: frame committed
//   cfg_err    one-cycle pulse: checksum mismatch, frame discarded
//   busy       high whenever the FSM is not in IDLE
//   dbg_state  current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where cfg_valid and cfg_ready
// are both high; cfg_valid may drop at any time and the FSM simply holds.
// cfg_ready depends only on the state register, never on cfg_valid.
// ---------------------------------------------------------------------------
module switch_config_loader
   import switch_cfg_pkg::*;
#(
   parameter int NUM_SW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic              sw_clear,
   output logic [NUM_SW-1:0] enable,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int NBYTES = cfg_nbytes(NUM_SW);
   localparam int CNT_W  = ($clog2(NBYTES + 1) < 1) ? 1 : $clog2(NBYTES + 1);
   localparam int SH_W   = 8 * NBYTES;

   cfg_state_t        r_state;
   cfg_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_acc;
   logic [7:0]        r_csum;
   logic [SH_W-1:0]   r_shadow;
   logic [NUM_SW-1:0] r_enable;
   logic              r_done;
   logic              r_err;
   logic              w_hs;
   logic              w_last_byte;
   logic              w_match;

   assign cfg_ready   = (r_state != APPLY);
   assign busy        = (r_state != IDLE);
   assign dbg_state   = r_state;
   assign enable      = r_enable;
   assign cfg_done    = r_done;
   assign cfg_err     = r_err;

   assign w_hs        = cfg_valid & cfg_ready;
   assign w_last_byte = (r_cnt == CNT_W'(NBYTES - 1));
   assign w_match     = (r_csum == r_acc);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; sw_clear overrides everything, including APPLY.
   always_comb begin
      w_state_nxt = r_state;
      if (sw_clear) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_hs && (cfg_data == CFG_HEADER)) w_state_nxt = PAYLOAD;
            PAYLOAD: if (w_hs && w_last_byte)              w_state_nxt = CSUM;
            CSUM:    if (w_hs)                             w_state_nxt = APPLY;
            APPLY:                                         w_state_nxt = IDLE;
            default:                                       w_state_nxt = IDLE;
         endcase
      end
   end

   // Datapath: byte counter, XOR accumulator, shadow, commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_csum   <= '0;
         r_shadow <= '0;
         r_enable <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (sw_clear) begin
            // Any same-cycle handshake is swallowed here.
            r_cnt    <= '0;
            r_acc    <= '0;
            r_enable <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_hs && (cfg_data == CFG_HEADER)) begin
                     r_cnt <= '0;
                     r_acc <= '0;
                  end
               end
               PAYLOAD: begin
                  if (w_hs) begin
                     for (int j = 0; j < NBYTES; j++) begin
                        if (r_cnt == CNT_W'(j)) r_shadow[8*j +: 8] <= cfg_data;
                     end
                     // Full byte is folded in, even bits above NUM_SW.
                     r_acc <= r_acc ^ cfg_data;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               CSUM: begin
                  if (w_hs) r_csum <= cfg_data;
               end
               APPLY: begin
                  if (w_match) begin
                     r_enable <= r_shadow[NUM_SW-1:0];
                     r_done   <= 1'b1;
                  end else begin
                     r_err    <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
